// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative 32-bit radix-2 restoring divider, result = {remainder, quotient}
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor through the DIVZERO state.
module div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

`ifdef DIV_ZERO_FAST_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_END = 2'd2, S_DIVZERO = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_END = 2'd2} state_t;
`endif

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_cnt;
   logic [32:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic        r_signed;
   logic        r_neg1;
   logic        r_neg2;
   logic [63:0] r_result;
   logic        r_ready;

   logic        w_accept;
   logic        w_last;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [32:0] w_rem_sh;
   logic        w_ge;
   logic [32:0] w_rem_nx;
   logic [31:0] w_quo_nx;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

   assign w_accept = start_i & ~annul_i;
   assign w_last   = (r_cnt == 6'd31);
   assign w_mag1   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_mag2   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // r_quo starts as the dividend and fills with quotient bits as dividend bits shift out
   assign w_rem_sh = {r_rem[31:0], r_quo[31]};
   assign w_ge     = r_rem[32] | (w_rem_sh >= {1'b0, r_dvs});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
   assign w_quo_nx = {r_quo[30:0], w_ge};

   assign w_q_fix  = (r_signed && (r_neg1 ^ r_neg2)) ? (~w_quo_nx + 32'd1) : w_quo_nx;
   assign w_r_fix  = (r_signed && r_neg1) ? (~w_rem_nx[31:0] + 32'd1) : w_rem_nx[31:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
               w_next = (opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
`else
               w_next = S_ON;
`endif
            end
         end
         S_ON: begin
            if (annul_i)     w_next = S_IDLE;
            else if (w_last) w_next = S_END;
         end
         S_END: begin
            if (!start_i) w_next = S_IDLE;
         end
`ifdef DIV_ZERO_FAST_EN
         S_DIVZERO: begin
            if (annul_i)               w_next = S_IDLE;
            else if (r_cnt == 6'd1)    w_next = S_END;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 6'd0;
         r_rem    <= 33'd0;
         r_quo    <= 32'd0;
         r_dvs    <= 32'd0;
         r_signed <= 1'b0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_result <= 64'd0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= 6'd0;
                  r_rem    <= 33'd0;
                  r_quo    <= w_mag1;
                  r_dvs    <= w_mag2;
                  r_signed <= signed_div_i;
                  r_neg1   <= opdata1_i[31];
                  r_neg2   <= opdata2_i[31];
               end
            end
            S_ON: begin
               if (!annul_i) begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt + 6'd1;
                  if (w_last) begin
                     r_result <= {w_r_fix, w_q_fix};
                     r_ready  <= 1'b1;
                  end
               end
            end
            S_END: begin
               if (!start_i) r_ready <= 1'b0;
            end
`ifdef DIV_ZERO_FAST_EN
            // zero divisor: result appears two edges after accept
            S_DIVZERO: begin
               if (!annul_i) begin
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == 6'd1) begin
                     r_result <= 64'd0;
                     r_ready  <= 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter: vector table, corner sequences, random ops
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] last_res;

   always #5 clk = ~clk;

   div_iter dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division with truncation toward zero
   function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
         return 64'd0;
`else
         return (sg && a[31]) ? {a, 32'h00000001} : {a, 32'hFFFFFFFF};
`endif
      end
      if (!sg) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 2;
`endif
      return (b == 32'd0) ? 32 : 32;
   endfunction

   task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int  lat;
      bit  seen;
      lat  = 0;
      seen = 1'b0;
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      @(posedge clk);
      #1;
      for (int j = 1; j <= 40 && !seen; j++) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom);
         @(posedge clk);
         #1;
         if (ready_o) begin
            seen = 1'b1;
            lat  = j;
         end
      end
      chk({name, " latency"}, 64'(lat), 64'(exp_latency(b)));
      chk({name, " result"}, result_o, exp);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk({name, " ready held in END"}, 64'(ready_o), 64'd1);
      chk({name, " result held in END"}, result_o, exp);
      start_i = 1'b0;
      annul_i = 1'b0;
      @(posedge clk);
      #1;
      chk({name, " ready dropped"}, 64'(ready_o), 64'd0);
      chk({name, " result held after drop"}, result_o, exp);
      last_res = exp;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit rose, changed;
      logic        sg;
      logic [31:0] a, b;

      vecs[0]  = '{1'b0, 32'd100,       32'd7,         64'h00000002_0000000E};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD};
      vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000};
`ifdef DIV_ZERO_FAST_EN
      vecs[4]  = '{1'b0, 32'd5,         32'd0,         64'h00000000_00000000};
      vecs[8]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         64'h00000000_00000000};
`else
      vecs[4]  = '{1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF};
      vecs[8]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         64'hFFFFFFFB_00000001};
`endif
      vecs[5]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF};
      vecs[6]  = '{1'b0, 32'd3,         32'd10,        64'h00000003_00000000};
      vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E};
      vecs[9]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001};
      vecs[10] = '{1'b1, 32'h80000000,  32'd1,         64'h00000000_80000000};

      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      rst = 1'b0;
      last_res = 64'd0;

      for (int i = 0; i < 11; i++)
         run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp);

      // annul on the 10th iteration
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      rose    = 1'b0;
      changed = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(posedge clk);
         #1;
         if (ready_o) rose = 1'b1;
         if (result_o !== last_res) changed = 1'b1;
      end
      chk("annul ready never rose", 64'(rose), 64'd0);
      chk("annul result unchanged", 64'(changed), 64'd0);
      chk("annul result value", result_o, last_res);
      run_op("after annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

      // reset during the 20th iteration
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midop reset ready", 64'(ready_o), 64'd0);
      chk("midop reset result", result_o, 64'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      rose    = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(posedge clk);
         #1;
         if (ready_o) rose = 1'b1;
      end
      chk("midop reset stays idle", 64'(rose), 64'd0);
      run_op("after reset", 1'b1, 32'hFFFFFC18, 32'd7, ref_div(1'b1, 32'hFFFFFC18, 32'd7));

      for (int i = 0; i < 40; i++) begin
         sg = 1'($urandom);
         a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFFFFFF;
            3:       b = a;
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), sg, a, b, ref_div(sg, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
